inter_tx_handshake: RTL and testbench



---
 rtl/inter_tx_handshake_pkg.sv | 46 ++++
 rtl/inter_msg_fifo.sv | 63 ++++++
 rtl/inter_tx_handshake.sv | 139 +++++++++++++
 tb/tb_inter_tx_handshake.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inter_tx_handshake_pkg.sv
// Shared definitions for the interboard transmit path: field widths, FSM
// state encoding, message type codes and the beat encoder.
package inter_tx_handshake_pkg;

    localparam int MSG_TYPE_W   = 3;
    localparam int NUM_W        = 5;
    localparam int MSG_W        = MSG_TYPE_W + NUM_W;
    localparam int INTER_DATA_W = 6;
    localparam int BEAT_IDX_BIT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } tx_state_e;

    // Message type codes shared with the game controllers
    typedef enum logic [MSG_TYPE_W-1:0] {
        MSG_NONE    = 3'd0,
        MSG_START   = 3'd1,
        MSG_MOVE    = 3'd2,
        MSG_SCORE   = 3'd3,
        MSG_HIT     = 3'd4,
        MSG_MISS    = 3'd5,
        MSG_WIN     = 3'd6,
        MSG_RESTART = 3'd7
    } msg_type_e;

    // Beat 0 carries the type, beat 1 the number; bit 5 flags which beat it is
    function automatic logic [INTER_DATA_W-1:0] encode_beat(
        input logic [MSG_W-1:0] msg,
        input logic             beat_idx
    );
        logic [INTER_DATA_W-1:0] b;
        b = '0;
        b[BEAT_IDX_BIT] = beat_idx;
        if (beat_idx) begin
            b[NUM_W-1:0] = msg[NUM_W-1:0];
        end else begin
            b[MSG_TYPE_W-1:0] = msg[MSG_W-1 -: MSG_TYPE_W];
        end
        return b;
    endfunction

endpackage

// File: rtl/inter_msg_fifo.sv
// Small synchronous first-word-fall-through FIFO for queued 8-bit messages.
// The head entry is always visible on pop_data while the FIFO is not empty.
module inter_msg_fifo
    import inter_tx_handshake_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = MSG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; a push and a pop together leave count alone
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/inter_tx_handshake.sv
// Transmit side of the interboard link: queues controller messages and sends
// each as two 6-bit beats over a four-phase Request/Ack handshake, with a
// synchronised Ack_in and a timeout that abandons a message if the peer dies.
module inter_tx_handshake
    import inter_tx_handshake_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_en,
    input  logic [MSG_TYPE_W-1:0]   ctrl_msg_type,
    input  logic [NUM_W-1:0]        ctrl_number,
    output logic                    inter_ready,
    input  logic                    Ack_in,
    output logic                    Request_out,
    output logic [INTER_DATA_W-1:0] inter_data_out,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    tx_state_e                 state;
    logic [MSG_W-1:0]          msg_reg;
    logic                      beat;
    logic [TW-1:0]             timer;
    logic [SYNC_STAGES-1:0]    ack_sync;
    logic                      ack_s;

    logic [MSG_W-1:0]          fifo_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      fifo_pop;

    assign ack_s       = ack_sync[SYNC_STAGES-1];
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign inter_ready = !fifo_full;
    assign busy        = (state != IDLE) || (fifo_count != '0);

    inter_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ctrl_en),
        .push_data ({ctrl_msg_type, ctrl_number}),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Bring the asynchronous peer acknowledge into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync[0] <= Ack_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ack_sync[i] <= ack_sync[i-1];
            end
        end
    end

    // Handshake sequencer; outputs are registered so the pins never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            msg_reg        <= '0;
            beat           <= 1'b0;
            timer          <= '0;
            Request_out    <= 1'b0;
            inter_data_out <= '0;
            timeout_err    <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        msg_reg <= fifo_data;
                        beat    <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    inter_data_out <= encode_beat(msg_reg, beat);
                    Request_out    <= 1'b0;
                    timer          <= '0;
                    state          <= REQ;
                end
                REQ: begin
                    // Only an ack seen while our request is visible counts,
                    // so a stale ack cannot skip the request phase
                    if (Request_out && ack_s) begin
                        Request_out <= 1'b0;
                        timer       <= '0;
                        state       <= REL;
                    end else if (timer == TIMER_LAST) begin
                        Request_out    <= 1'b0;
                        inter_data_out <= '0;
                        timeout_err    <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        Request_out <= 1'b1;
                        timer       <= timer + 1'b1;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        if (!beat) begin
                            beat  <= 1'b1;
                            state <= SETUP;
                        end else begin
                            inter_data_out <= '0;
                            state          <= IDLE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        inter_data_out <= '0;
                        timeout_err    <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inter_tx_handshake.sv
// Directed bench for inter_tx_handshake: a peer model answers the four-phase
// handshake, and each scenario task checks beats, timing and FIFO behaviour.
module tb_inter_tx_handshake;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl_en = 1'b0;
    logic [2:0] ctrl_msg_type = '0;
    logic [4:0] ctrl_number = '0;
    logic       Ack_in = 1'b0;
    logic       inter_ready;
    logic       Request_out;
    logic [5:0] inter_data_out;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    bit peer_en = 1'b0;
    bit mon_en = 1'b0;
    int stab_viol = 0;

    logic [5:0] beats_q[$];
    bit         collect_timed_out;

    inter_tx_handshake #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_en        (ctrl_en),
        .ctrl_msg_type  (ctrl_msg_type),
        .ctrl_number    (ctrl_number),
        .inter_ready    (inter_ready),
        .Ack_in         (Ack_in),
        .Request_out    (Request_out),
        .inter_data_out (inter_data_out),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // Peer board: raises Ack 3 cycles after Request rises, drops it 3 cycles after Request falls
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #3;
            if (!peer_en) begin
                Ack_in = 1'b0;
                cnt = 0;
            end else if (Request_out && !Ack_in) begin
                cnt++;
                if (cnt == 3) begin
                    Ack_in = 1'b1;
                    cnt = 0;
                end
            end else if (!Request_out && Ack_in) begin
                cnt++;
                if (cnt == 3) begin
                    Ack_in = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Data must not move while Request is high, nor during release until the synchronised ack has fallen
    initial begin
        logic [5:0] prev_data;
        bit         prev_hold;
        int         ack_low;
        prev_data = '0;
        prev_hold = 1'b0;
        ack_low = 0;
        forever begin
            @(negedge clk);
            if (Ack_in) ack_low = 0;
            else if (ack_low < 100) ack_low++;
            if (mon_en && prev_hold && (inter_data_out !== prev_data)) stab_viol++;
            prev_hold = Request_out || Ack_in || (ack_low < 3);
            prev_data = inter_data_out;
        end
    end

    // Global safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_msg(input logic [2:0] t, input logic [4:0] n);
        @(posedge clk);
        #1;
        ctrl_en = 1'b1;
        ctrl_msg_type = t;
        ctrl_number = n;
        @(posedge clk);
        #1;
        ctrl_en = 1'b0;
    endtask

    task automatic collect_beats(input int budget);
        logic prev_req;
        beats_q.delete();
        collect_timed_out = 1'b1;
        prev_req = Request_out;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (Request_out && !prev_req) beats_q.push_back(inter_data_out);
            prev_req = Request_out;
            if (!busy) begin
                collect_timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ctrl_en = 1'b1;
        ctrl_msg_type = 3'd4;
        ctrl_number = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (Request_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_request: got %b expected 0", Request_out); end
        checks++; if (inter_data_out !== 6'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", inter_data_out); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (inter_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", inter_ready); end
        rst = 1'b0;
        ctrl_en = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl_en_ignored: busy got %b expected 0", busy); end
    endtask

    task automatic test_single_message();
        int         rises;
        bit         done;
        logic       prev_req;
        logic [5:0] seen[$];
        rises = 0;
        done = 1'b0;
        prev_req = 1'b0;
        peer_en = 1'b1;
        stab_viol = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        ctrl_en = 1'b1;
        ctrl_msg_type = 3'd2;
        ctrl_number = 5'd17;
        @(posedge clk);
        #1;
        ctrl_en = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_start: got %b expected 1", busy); end
            end
            if (k == 3) begin
                checks++; if (inter_data_out !== 6'b000010) begin errors++; $display("[TB] FAIL single_data_n2: got %b expected 000010", inter_data_out); end
                checks++; if (Request_out !== 1'b0) begin errors++; $display("[TB] FAIL single_req_n2: got %b expected 0", Request_out); end
            end
            if (k == 4) begin
                checks++; if (Request_out !== 1'b1) begin errors++; $display("[TB] FAIL single_req_n3: got %b expected 1", Request_out); end
            end
            if (Request_out && !prev_req) begin
                rises++;
                seen.push_back(inter_data_out);
            end
            prev_req = Request_out;
            if (k > 4 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        mon_en = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL single_complete: busy still high after 200 cycles, got done=%b expected 1", done); end
        checks++; if (rises !== 2) begin errors++; $display("[TB] FAIL single_pulses: got %0d expected 2", rises); end
        checks++; if (seen[0] !== 6'b000010) begin errors++; $display("[TB] FAIL single_beat0: got %b expected 000010", seen[0]); end
        checks++; if (seen[1] !== 6'b110001) begin errors++; $display("[TB] FAIL single_beat1: got %b expected 110001", seen[1]); end
        checks++; if (inter_data_out !== 6'd0) begin errors++; $display("[TB] FAIL single_data_idle: got %b expected 000000", inter_data_out); end
        checks++; if (stab_viol !== 0) begin errors++; $display("[TB] FAIL data_stability: got %0d changes expected 0", stab_viol); end
    endtask

    task automatic test_timeout();
        int         to_pulses;
        int         to_k;
        int         req_cnt;
        bit         done;
        logic       prev_req;
        logic [5:0] seen[$];
        to_pulses = 0;
        to_k = 0;
        req_cnt = 0;
        done = 1'b0;
        prev_req = 1'b0;
        peer_en = 1'b0;
        @(posedge clk);
        #1;
        ctrl_en = 1'b1;
        ctrl_msg_type = 3'd5;
        ctrl_number = 5'd9;
        @(posedge clk);
        #1;
        ctrl_en = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 5) begin
                ctrl_en = 1'b1;
                ctrl_msg_type = 3'd1;
                ctrl_number = 5'd30;
            end
            if (k == 6) ctrl_en = 1'b0;
            if (timeout_err) begin
                to_pulses++;
                if (to_k == 0) to_k = k;
                peer_en = 1'b1;
            end
            if (to_k == 0 && Request_out) req_cnt++;
            if (k == 19) begin
                checks++; if (Request_out !== 1'b0) begin errors++; $display("[TB] FAIL timeout_req_drop: got %b expected 0", Request_out); end
                checks++; if (inter_data_out !== 6'd0) begin errors++; $display("[TB] FAIL timeout_data_clear: got %b expected 000000", inter_data_out); end
            end
            if (k == 21) begin
                checks++; if (inter_data_out !== 6'b000001) begin errors++; $display("[TB] FAIL timeout_next_beat0: got %b expected 000001", inter_data_out); end
                checks++; if (Request_out !== 1'b0) begin errors++; $display("[TB] FAIL timeout_next_setup: got %b expected 0", Request_out); end
            end
            if (to_k != 0 && Request_out && !prev_req) seen.push_back(inter_data_out);
            prev_req = Request_out;
            if (k > 21 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_complete: got done=%b expected 1", done); end
        checks++; if (to_pulses !== 1) begin errors++; $display("[TB] FAIL timeout_pulses: got %0d expected 1", to_pulses); end
        checks++; if (to_k !== 19) begin errors++; $display("[TB] FAIL timeout_cycle: got %0d expected 19", to_k); end
        checks++; if (req_cnt !== 15) begin errors++; $display("[TB] FAIL timeout_req_len: got %0d expected 15", req_cnt); end
        checks++; if (seen.size() !== 2) begin errors++; $display("[TB] FAIL timeout_next_beats: got %0d expected 2", seen.size()); end
        checks++; if (seen[0] !== 6'b000001) begin errors++; $display("[TB] FAIL timeout_next_b0: got %b expected 000001", seen[0]); end
        checks++; if (seen[1] !== 6'b111110) begin errors++; $display("[TB] FAIL timeout_next_b1: got %b expected 111110", seen[1]); end
    endtask

    task automatic test_fifo_full();
        logic [2:0] types [6];
        logic [4:0] nums [6];
        logic [5:0] exp_b [8];
        bit         seen_to;
        types = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        nums  = '{5'd2, 5'd5, 5'd8, 5'd11, 5'd14, 5'd17};
        exp_b = '{6'h02, 6'h25, 6'h03, 6'h28, 6'h04, 6'h2B, 6'h05, 6'h2E};
        seen_to = 1'b0;
        peer_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_msg(types[i], nums[i]);
            @(negedge clk);
            if (i == 3) begin
                checks++; if (inter_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_4th: got %b expected 1", inter_ready); end
            end
            if (i >= 4) begin
                checks++; if (inter_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_push%0d: got %b expected 0", i + 1, inter_ready); end
                checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("[TB] FAIL full_count_push%0d: got %0d expected 4", i + 1, dut.u_fifo.count); end
            end
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (timeout_err) begin
                seen_to = 1'b1;
                break;
            end
        end
        checks++; if (seen_to !== 1'b1) begin errors++; $display("[TB] FAIL full_first_abort: got %b expected 1", seen_to); end
        peer_en = 1'b1;
        collect_beats(400);
        checks++; if (collect_timed_out !== 1'b0) begin errors++; $display("[TB] FAIL full_drain_done: got timeout=%b expected 0", collect_timed_out); end
        checks++; if (beats_q.size() !== 8) begin errors++; $display("[TB] FAIL full_drain_beats: got %0d expected 8", beats_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (beats_q[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL full_drain_beat%0d: got %h expected %h", i, beats_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        peer_en = 1'b1;
        push_msg(3'd6, 5'd20);
        push_msg(3'd7, 5'd21);
        push_msg(3'd0, 5'd22);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (Request_out && inter_data_out[5]) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_reach_beat1: got %b expected 1", found); end
        rst = 1'b1;
        ctrl_en = 1'b1;
        ctrl_msg_type = 3'd7;
        ctrl_number = 5'd31;
        @(negedge clk);
        checks++; if (Request_out !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_request: got %b expected 0", Request_out); end
        checks++; if (inter_data_out !== 6'd0) begin errors++; $display("[TB] FAIL rstmid_data: got %h expected 00", inter_data_out); end
        checks++; if (inter_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b expected 1", inter_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ctrl_en_ignored: got %b expected 0", busy); end
        rst = 1'b0;
        ctrl_en = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flushed: got %b expected 0", busy); end
        push_msg(3'd3, 5'd24);
        collect_beats(200);
        checks++; if (collect_timed_out !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after_done: got timeout=%b expected 0", collect_timed_out); end
        checks++; if (beats_q.size() !== 2) begin errors++; $display("[TB] FAIL rstmid_after_beats: got %0d expected 2", beats_q.size()); end
        checks++; if (beats_q[0] !== 6'h03) begin errors++; $display("[TB] FAIL rstmid_after_b0: got %h expected 03", beats_q[0]); end
        checks++; if (beats_q[1] !== 6'h38) begin errors++; $display("[TB] FAIL rstmid_after_b1: got %h expected 38", beats_q[1]); end
    endtask

    task automatic test_push_pop();
        bit         found;
        logic [5:0] prev_d;
        logic [5:0] exp_b [6];
        exp_b = '{6'h02, 6'h22, 6'h03, 6'h23, 6'h04, 6'h24};
        found = 1'b0;
        peer_en = 1'b1;
        push_msg(3'd1, 5'd1);
        push_msg(3'd2, 5'd2);
        push_msg(3'd3, 5'd3);
        prev_d = inter_data_out;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!Request_out && inter_data_out == 6'd0 && prev_d[5]) begin
                found = 1'b1;
                break;
            end
            prev_d = inter_data_out;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_idle_seen: got %b expected 1", found); end
        checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("[TB] FAIL pushpop_count_before: got %0d expected 2", dut.u_fifo.count); end
        ctrl_en = 1'b1;
        ctrl_msg_type = 3'd4;
        ctrl_number = 5'd4;
        @(posedge clk);
        #1;
        ctrl_en = 1'b0;
        @(negedge clk);
        checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("[TB] FAIL pushpop_count_after: got %0d expected 2", dut.u_fifo.count); end
        collect_beats(400);
        checks++; if (collect_timed_out !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_done: got timeout=%b expected 0", collect_timed_out); end
        checks++; if (beats_q.size() !== 6) begin errors++; $display("[TB] FAIL pushpop_beats: got %0d expected 6", beats_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (beats_q[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL pushpop_beat%0d: got %h expected %h", i, beats_q[i], exp_b[i]); end
        end
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] starting inter_tx_handshake bench");
        test_reset();
        test_single_message();
        test_timeout();
        test_fifo_full();
        test_reset_mid();
        test_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
